// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and payload layout for the MEM->WB stage
package wb_pkg;
  localparam int XLEN_DEF = 64;
  localparam int RD_W_DEF = 5;
  typedef struct packed {
    logic [XLEN_DEF-1:0] read_data;
    logic [XLEN_DEF-1:0] result;
    logic [RD_W_DEF-1:0] rd;
    logic                mem_to_reg;
    logic                reg_write;
  } wb_payload_t;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: valid/ready register stage, optional second slot so in_ready can be registered
module skid_buffer #(
  parameter int WIDTH = 8,
  parameter int SKID  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             head_v;
  logic [WIDTH-1:0] head_d;
  logic             take;
  assign take      = in_valid & in_ready;
  assign out_valid = head_v;
  assign out_data  = head_d;
  generate
    if (SKID != 0) begin : g_skid
      logic             skid_v;
      logic [WIDTH-1:0] skid_d;
      assign in_ready = !skid_v;
      // skid only fills while the head is held, so it always holds the younger entry
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          head_v <= 1'b0;
          skid_v <= 1'b0;
          head_d <= '0;
          skid_d <= '0;
        end else if (flush) begin
          head_v <= 1'b0;
          skid_v <= 1'b0;
        end else if (skid_v) begin
          if (out_ready) begin
            head_d <= skid_d;
            skid_v <= 1'b0;
          end
        end else if (take) begin
          if (!head_v || out_ready) begin
            head_d <= in_data;
            head_v <= 1'b1;
          end else begin
            skid_d <= in_data;
            skid_v <= 1'b1;
          end
        end else if (out_ready) begin
          head_v <= 1'b0;
        end
    end else begin : g_reg
      assign in_ready = !head_v | out_ready;
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          head_v <= 1'b0;
          head_d <= '0;
        end else if (flush) begin
          head_v <= 1'b0;
        end else if (take) begin
          head_d <= in_data;
          head_v <= 1'b1;
        end else if (out_ready) begin
          head_v <= 1'b0;
        end
    end
  endgenerate
endmodule

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: MEM->WB handshake stage with write-back mux and forwarding tap
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF,
  parameter int SKID = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_read_data,
  input  logic [XLEN-1:0] in_result,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_mem_to_reg,
  input  logic            in_reg_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_read_data,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_mem_to_reg,
  output logic            out_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);
  localparam int W = 2 * XLEN + RD_W + 2;
  logic [W-1:0] in_pl, out_pl;
  assign in_pl = {in_read_data, in_result, in_rd, in_mem_to_reg, in_reg_write};
  assign {out_read_data, out_result, out_rd, out_mem_to_reg, out_reg_write} = out_pl;
  skid_buffer #(.WIDTH(W), .SKID(SKID)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl)
  );
  // x0 is hardwired zero, so it must never look like a producer to the hazard unit
  assign wb_data   = out_mem_to_reg ? out_read_data : out_result;
  assign fwd_valid = out_valid & out_reg_write & (out_rd != '0);
  assign wb_we     = fwd_valid & out_ready;
  assign fwd_rd    = out_rd;
  assign fwd_data  = wb_data;
endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb_wb_pipe_stage: directed and randomized checks of both SKID builds against a FIFO model
module tb_wb_pipe_stage;
  import wb_pkg::*;
  logic        clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_read_data = '0, in_result = '0;
  logic [4:0]  in_rd = '0;
  logic        in_mem_to_reg = 1'b0, in_reg_write = 1'b0;
  logic        in_ready, out_valid, out_mem_to_reg, out_reg_write, wb_we, fwd_valid;
  logic [63:0] out_read_data, out_result, wb_data, fwd_data;
  logic [4:0]  out_rd, fwd_rd;
  logic        z_in_ready, z_out_valid, z_out_mem_to_reg, z_out_reg_write, z_wb_we, z_fwd_valid;
  logic [63:0] z_out_read_data, z_out_result, z_wb_data, z_fwd_data;
  logic [4:0]  z_out_rd, z_fwd_rd;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  wb_pipe_stage #(.SKID(1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_read_data(in_read_data), .in_result(in_result), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_read_data(out_read_data),
    .out_result(out_result), .out_rd(out_rd), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .wb_data(wb_data), .wb_we(wb_we),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  wb_pipe_stage #(.SKID(0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_read_data(in_read_data), .in_result(in_result), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_read_data(z_out_read_data),
    .out_result(z_out_result), .out_rd(z_out_rd), .out_mem_to_reg(z_out_mem_to_reg),
    .out_reg_write(z_out_reg_write), .wb_data(z_wb_data), .wb_we(z_wb_we),
    .fwd_valid(z_fwd_valid), .fwd_rd(z_fwd_rd), .fwd_data(z_fwd_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rd, input logic [63:0] res,
                     input logic [63:0] rdat, input logic m2r, input logic rw);
    in_valid = v; in_rd = rd; in_result = res; in_read_data = rdat;
    in_mem_to_reg = m2r; in_reg_write = rw;
  endtask

  task automatic clear();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #10;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (wb_data !== 64'd0 || out_rd !== 5'd0 || fwd_valid !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL rst_outputs wb_data=%h rd=%0d fwd_valid=%b wb_we=%b want all 0", wb_data, out_rd, fwd_valid, wb_we); end
    total++; if (z_in_ready !== 1'b1 || z_out_valid !== 1'b0) begin bad++; $display("FAIL rst_skid0 in_ready=%b out_valid=%b want 1/0", z_in_ready, z_out_valid); end
    tick();
    reset = 1'b1;
    out_ready = 1'b0;
    put(1, 5'd1, 64'h10, 64'h0, 0, 1);
    tick();
    put(1, 5'd2, 64'h20, 64'h0, 0, 1);
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL rst_fill in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || wb_we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_async out_valid=%b wb_we=%b in_ready=%b want 0/0/1", out_valid, wb_we, in_ready); end
    total++; if (z_out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_skid0 out_valid=%b want 0", z_out_valid); end
    #1 reset = 1'b1;
    out_ready = 1'b1;
    put(1, 5'd5, 64'h50, 64'h0, 0, 1);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_early out_valid=%b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin bad++; $display("FAIL rst_first_entry out_valid=%b rd=%0d want 1/5", out_valid, out_rd); end
    tick();
  endtask

  task automatic test_stream();
    clear();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(1, 5'(i), 64'(i * 16), 64'hFFFF, 0, 1);
      tick();
      total++; if (out_valid !== 1'b1 || out_rd !== 5'(i) || wb_data !== 64'(i * 16) || wb_we !== 1'b1) begin bad++; $display("FAIL stream[%0d] valid=%b rd=%0d wb_data=%h we=%b want 1/%0d/%h/1", i, out_valid, out_rd, wb_data, wb_we, i, i * 16); end
      total++; if (z_out_valid !== 1'b1 || z_out_rd !== 5'(i) || z_wb_we !== 1'b1) begin bad++; $display("FAIL stream0[%0d] valid=%b rd=%0d we=%b want 1/%0d/1", i, z_out_valid, z_out_rd, z_wb_we, i); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || z_out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain valid=%b/%b want 0/0", out_valid, z_out_valid); end
  endtask

  task automatic test_stall();
    clear();
    out_ready = 1'b0;
    put(1, 5'd1, 64'hA, 64'h0, 0, 1);
    tick();
    put(1, 5'd2, 64'hB, 64'h0, 0, 1);
    tick();
    put(1, 5'd3, 64'hC, 64'h0, 0, 1);
    total++; if (in_ready !== 1'b0 || out_rd !== 5'd1 || out_result !== 64'hA) begin bad++; $display("FAIL stall_full in_ready=%b rd=%0d result=%h want 0/1/a", in_ready, out_rd, out_result); end
    tick();
    total++; if (in_ready !== 1'b0 || out_rd !== 5'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold in_ready=%b rd=%0d valid=%b want 0/1/1", in_ready, out_rd, out_valid); end
    out_ready = 1'b1;
    tick();
    total++; if (out_rd !== 5'd2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_rel_b rd=%0d in_ready=%b valid=%b want 2/1/1", out_rd, in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (out_rd !== 5'd3 || out_result !== 64'hC || out_valid !== 1'b1) begin bad++; $display("FAIL stall_rel_c rd=%0d result=%h valid=%b want 3/c/1", out_rd, out_result, out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    clear();
    out_ready = 1'b0;
    put(1, 5'd4, 64'h44, 64'h0, 0, 1);
    tick();
    put(1, 5'd9, 64'h99, 64'h0, 0, 1);
    flush = 1'b1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre in_ready=%b valid=%b want 1/1", in_ready, out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b0 || z_out_valid !== 1'b0 || wb_we !== 1'b0) begin bad++; $display("FAIL flush_kill[%0d] valid=%b/%b we=%b want 0/0/0", i, out_valid, z_out_valid, wb_we); end
      tick();
    end
  endtask

  task automatic test_wb_fwd();
    clear();
    out_ready = 1'b0;
    put(1, 5'd7, 64'h1234, 64'hDEAD_BEEF, 1, 1);
    tick();
    in_valid = 1'b0;
    total++; if (wb_data !== 64'hDEAD_BEEF || fwd_data !== 64'hDEAD_BEEF || fwd_rd !== 5'd7 || fwd_valid !== 1'b1 || wb_we !== 1'b0) begin bad++; $display("FAIL wb_load wb=%h fd=%h frd=%0d fv=%b we=%b want deadbeef/deadbeef/7/1/0", wb_data, fwd_data, fwd_rd, fwd_valid, wb_we); end
    out_ready = 1'b1;
    #1;
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL wb_we_comb got=%b want 1", wb_we); end
    put(1, 5'd0, 64'h1234, 64'hDEAD_BEEF, 1, 1);
    tick();
    total++; if (out_valid !== 1'b1 || wb_we !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL wb_x0 valid=%b we=%b fv=%b want 1/0/0", out_valid, wb_we, fwd_valid); end
    put(1, 5'd12, 64'h1234, 64'hDEAD_BEEF, 0, 1);
    tick();
    total++; if (wb_data !== 64'h1234 || wb_we !== 1'b1) begin bad++; $display("FAIL wb_alu wb=%h we=%b want 1234/1", wb_data, wb_we); end
    put(1, 5'd12, 64'h1234, 64'hDEAD_BEEF, 0, 0);
    tick();
    in_valid = 1'b0;
    total++; if (wb_we !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL wb_nowrite we=%b fv=%b want 0/0", wb_we, fwd_valid); end
    tick();
  endtask

  task automatic test_skid0();
    clear();
    out_ready = 1'b0;
    put(1, 5'd3, 64'h33, 64'h0, 0, 1);
    tick();
    in_valid = 1'b0;
    total++; if (z_in_ready !== 1'b0 || z_out_valid !== 1'b1) begin bad++; $display("FAIL skid0_stall in_ready=%b valid=%b want 0/1", z_in_ready, z_out_valid); end
    out_ready = 1'b1;
    #1;
    total++; if (z_in_ready !== 1'b1) begin bad++; $display("FAIL skid0_comb in_ready=%b want 1", z_in_ready); end
    put(1, 5'd4, 64'h44, 64'h0, 0, 1);
    tick();
    in_valid = 1'b0;
    total++; if (z_out_valid !== 1'b1 || z_out_rd !== 5'd4 || z_out_result !== 64'h44) begin bad++; $display("FAIL skid0_replace valid=%b rd=%0d res=%h want 1/4/44", z_out_valid, z_out_rd, z_out_result); end
    tick();
    total++; if (z_out_valid !== 1'b0) begin bad++; $display("FAIL skid0_drain valid=%b want 0", z_out_valid); end
  endtask

  task automatic test_random();
    wb_payload_t q1[$], q0[$], cur, h;
    logic ex_v, ex_r, ex_we, ex_fv;
    logic [63:0] ex_wb;
    clear();
    for (int c = 0; c < 600; c++) begin
      put($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
          {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      cur = '{read_data: in_read_data, result: in_result, rd: in_rd, mem_to_reg: in_mem_to_reg, reg_write: in_reg_write};
      #1;
      // SKID=1: capacity two, in_ready means "not full"
      ex_v = q1.size() != 0;
      ex_r = q1.size() < 2;
      h = ex_v ? q1[0] : '0;
      ex_wb = h.mem_to_reg ? h.read_data : h.result;
      ex_fv = ex_v && h.reg_write && h.rd != 0;
      ex_we = ex_fv && out_ready;
      total++; if (out_valid !== ex_v || in_ready !== ex_r || wb_we !== ex_we || fwd_valid !== ex_fv) begin bad++; $display("FAIL rnd1[%0d] v=%b r=%b we=%b fv=%b want %b/%b/%b/%b", c, out_valid, in_ready, wb_we, fwd_valid, ex_v, ex_r, ex_we, ex_fv); end
      if (ex_v) begin
        total++; if (out_rd !== h.rd || wb_data !== ex_wb || out_result !== h.result || out_read_data !== h.read_data) begin bad++; $display("FAIL rnd1_data[%0d] rd=%0d wb=%h want rd=%0d wb=%h", c, out_rd, wb_data, h.rd, ex_wb); end
      end
      // SKID=0: capacity one, in_ready passes straight through out_ready
      ex_v = q0.size() != 0;
      ex_r = q0.size() == 0 || out_ready;
      h = ex_v ? q0[0] : '0;
      ex_wb = h.mem_to_reg ? h.read_data : h.result;
      ex_fv = ex_v && h.reg_write && h.rd != 0;
      ex_we = ex_fv && out_ready;
      total++; if (z_out_valid !== ex_v || z_in_ready !== ex_r || z_wb_we !== ex_we || z_fwd_valid !== ex_fv) begin bad++; $display("FAIL rnd0[%0d] v=%b r=%b we=%b fv=%b want %b/%b/%b/%b", c, z_out_valid, z_in_ready, z_wb_we, z_fwd_valid, ex_v, ex_r, ex_we, ex_fv); end
      if (ex_v) begin
        total++; if (z_out_rd !== h.rd || z_wb_data !== ex_wb) begin bad++; $display("FAIL rnd0_data[%0d] rd=%0d wb=%h want rd=%0d wb=%h", c, z_out_rd, z_wb_data, h.rd, ex_wb); end
      end
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (in_valid && q1.size() < 2) begin
          if (q1.size() != 0 && out_ready) void'(q1.pop_front());
          q1.push_back(cur);
        end else if (q1.size() != 0 && out_ready) void'(q1.pop_front());
        if (in_valid && (q0.size() == 0 || out_ready)) begin
          q0.delete();
          q0.push_back(cur);
        end else if (q0.size() != 0 && out_ready) void'(q0.pop_front());
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_wb_fwd();
    test_skid0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

- Parametrised MEM→WB pipeline stage that replaces the fixed 64-bit, always-advancing MEM/WB register.
- Adds a valid/ready handshake, stall without bubble loss, and a synchronous flush.
- Optional skid buffer gives full throughput while registering `in_ready`.
- Also produces the final write-back value, write enable and a forwarding tap for the hazard unit.

## Interface
Parameters:
- `XLEN`, default 64: width of `read_data` and `result`.
- `RD_W`, default 5: destination register address width.
- `SKID`, default 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: **asynchronous, active-low**. Asserted when 0.
- `flush` input 1: synchronous kill of all held entries.
- `in_valid` input 1: MEM stage offers an entry.
- `in_ready` output 1: stage accepts an entry this cycle.
- `in_read_data` input XLEN: load data from data memory.
- `in_result` input XLEN: ALU result.
- `in_rd` input RD_W: destination register.
- `in_mem_to_reg` input 1: select load data for write-back.
- `in_reg_write` input 1: instruction writes the register file.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: write-back consumes the head entry (normally tied 1).
- `out_read_data`, `out_result`, `out_rd`, `out_mem_to_reg`, `out_reg_write`: head entry fields, same widths as the inputs.
- `wb_data` output XLEN: `out_mem_to_reg ? out_read_data : out_result`.
- `wb_we` output 1: `out_valid & out_ready & out_reg_write & (out_rd != 0)`.
- `fwd_valid` output 1: `out_valid & out_reg_write & (out_rd != 0)`.
- `fwd_rd` output RD_W: equals `out_rd`.
- `fwd_data` output XLEN: equals `wb_data`.

## Operation
- Transfers:
  - An input transfer occurs on an edge where `in_valid & in_ready`.
  - An output transfer occurs on an edge where `out_valid & out_ready`.
- **SKID=0:**
  - `in_ready = !out_valid | out_ready`.
  - On an input transfer, the head loads the input fields and `out_valid` is set.
  - On an output transfer with no input transfer, `out_valid` is cleared.
- **SKID=1:**
  - There are two slots, head and skid; `in_ready` is registered and equals `!skid_valid`.
  - Input arrives with head empty, or head draining and skid empty: input goes to the head.
  - Input arrives while head is held (`out_valid & !out_ready`): input goes to the skid and `in_ready` falls the next cycle.
  - Head drains with skid valid: skid moves to the head, skid clears, `in_ready` rises.
  - Entries always leave in arrival order. No entry is duplicated or dropped except by flush.
- **Flush:**
  - On an edge with `flush=1`, `out_valid` and `skid_valid` clear.
  - Any simultaneous input transfer is discarded.
  - Payload registers may keep stale data; only the valid bits are cleared.
  - Flush has priority over every other event.
- Invalid entries:
  - `wb_we` and `fwd_valid` are 0 whenever `out_valid` is 0.
  - A write to x0 never asserts `wb_we` or `fwd_valid`.

## Timing
- Reset (asynchronous, level while `reset=0`):
  - `out_valid`, skid valid, all payload outputs, `wb_data`, `wb_we` and all `fwd_*` outputs are 0.
  - `in_ready` is 1 for SKID=1, and 1 for SKID=0 via its combinational equation.
- Latency: one cycle from input transfer to `out_valid` when the stage is empty.
- Throughput: one entry per cycle under continuous `out_ready=1`, in both modes.
- Stall:
  - With `out_ready=0`, head outputs stay stable.
  - SKID=1 absorbs exactly one extra entry, then `in_ready` drops.
- Reset asserted mid-operation: all held entries are lost immediately (asynchronously). There is no transfer on the edge where reset releases.
- `wb_data`, `wb_we` and `fwd_*` are combinational from the head registers and `out_ready`. No extra cycle.

## Structure
- Package `wb_pkg` holds:
  - constants `XLEN_DEF=64` and `RD_W_DEF=5`;
  - `typedef struct packed wb_payload_t` with fields read_data, result, rd, mem_to_reg, reg_write, at the default widths.
- Sub-module `skid_buffer`:
  - Generic `WIDTH`/`SKID` valid-ready register.
  - Has flush input.
  - `wb_pipe_stage` instantiates it on the packed payload and adds the write-back mux and forwarding logic.

## Test plan
- **Reset:** drive `reset=0` mid-stream with both slots full → `out_valid=0`, `wb_we=0` and `in_ready=1` immediately; after release, first input appears 1 cycle after acceptance.
- **Streaming:** 8 back-to-back entries with `out_ready=1`, `rd`=1..8 and `result=rd*16` → outputs in order one per cycle, `wb_data=result`, `wb_we=1` each cycle.
- **Stall with skid (SKID=1):** hold `out_ready=0` while sending A, B, C → A at head, B in skid, `in_ready=0` and C held; release → A, B, C in order with no loss.
- **Flush:** flush while the head is valid and an input transfer occurs in the same cycle → next cycle `out_valid=0`; the input entry is never output.
- **Write-back and forwarding:**
  - `mem_to_reg=1`, `read_data=0xDEAD_BEEF`, `result=0x1234`, `rd=7` → `wb_data=0xDEADBEEF`, `fwd_rd=7`, `fwd_valid=1`.
  - Same entry with `rd=0` → `wb_we=0`, `fwd_valid=0`.
- **SKID=0 build:** with `out_ready=0` and the head valid → `in_ready=0` combinationally; with `out_ready=1` → accept and replace in the same edge.
